// File: rtl/dsp_simd_addsub_pipe.sv
// rtl/dsp_simd_addsub_pipe.sv - pipelined SIMD signed add/sub/accumulate unit with valid/ready and warm-up hold-off
//
// Splits the packed a/b buses into LANES independent WIDTH-bit two's-complement
// lanes. Every lane applies the same op to its own slice and keeps its own
// accumulator. Results appear LATENCY cycles after acceptance.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   operand beat valid
//   in_ready   unit can accept a beat this cycle (warm-up done and not stalled)
//   op         00 a+b, 01 a-b, 10 acc+a, 11 acc=a
//   a, b       packed operands, lane i at [i*WIDTH +: WIDTH]; b unused for op 1x
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   y          packed result, same lane packing as a
//   ovf        per-lane signed overflow of the reported result
//   init_done  warm-up complete
module dsp_simd_addsub_pipe #(
    parameter int WIDTH       = 8,
    parameter int LANES       = 4,
    parameter int LATENCY     = 2,
    parameter int INIT_CYCLES = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [WIDTH*LANES-1:0]   a,
    input  logic [WIDTH*LANES-1:0]   b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*LANES-1:0]   y,
    output logic [LANES-1:0]         ovf,
    output logic                     init_done
);

    localparam int          DW     = WIDTH * LANES;
    localparam logic [16:0] INIT_L = 17'(INIT_CYCLES);

    logic [16:0]      cnt_q;
    logic [16:0]      cnt_d;
    logic             init_q;
    logic [LATENCY-1:0] vld_q;
    logic [DW-1:0]    res_q [LATENCY];
    logic [LANES-1:0] flg_q [LATENCY];
    logic [DW-1:0]    acc_q;
    logic [DW-1:0]    acc_d;
    logic [DW-1:0]    res_d;
    logic [LANES-1:0] flg_d;
    logic             stall;
    logic             accept;

    assign out_valid = vld_q[LATENCY-1];
    assign y         = res_q[LATENCY-1];
    assign ovf       = flg_q[LATENCY-1];
    assign init_done = init_q;

    assign stall     = out_valid && !out_ready;
    assign in_ready  = init_q && !stall;
    assign accept    = in_valid && in_ready;

    // Counter saturates at INIT_CYCLES so it never wraps on long runs.
    assign cnt_d = (cnt_q == INIT_L) ? cnt_q : cnt_q + 17'd1;

    // One lane: returns {overflow, result}. Overflow is detected from sign bits:
    // an add overflows only when both operands share a sign the result lacks.
    function automatic logic [WIDTH:0] lane_op(
        input logic [1:0]       f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z,
        input logic [WIDTH-1:0] acc
    );
        logic [WIDTH-1:0] s;
        logic             o;
        case (f)
            2'b00: begin
                s = x + z;
                o = (x[WIDTH-1] == z[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
            end
            2'b01: begin
                s = x - z;
                o = (x[WIDTH-1] != z[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
            end
            2'b10: begin
                s = acc + x;
                o = (acc[WIDTH-1] == x[WIDTH-1]) && (s[WIDTH-1] != acc[WIDTH-1]);
            end
            default: begin
                s = x;
                o = 1'b0;
            end
        endcase
        return {o, s};
    endfunction

    always_comb begin
        res_d = '0;
        flg_d = '0;
        for (int l = 0; l < LANES; l++) begin
            {flg_d[l], res_d[l*WIDTH +: WIDTH]} =
                lane_op(op, a[l*WIDTH +: WIDTH], b[l*WIDTH +: WIDTH], acc_q[l*WIDTH +: WIDTH]);
        end
        // For both accumulate and load the new accumulator equals the lane result.
        acc_d = (accept && op[1]) ? res_d : acc_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q  <= '0;
            init_q <= 1'b0;
            vld_q  <= '0;
            acc_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == INIT_L) begin
                init_q <= 1'b1;
            end
            acc_q <= acc_d;
            if (!stall) begin
                vld_q[0] <= accept;
                if (accept) begin
                    res_q[0] <= res_d;
                    flg_q[0] <= flg_d;
                end
                // Data only moves with a valid beat so y/ovf keep the last
                // result when a bubble reaches the output.
                for (int i = 1; i < LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        res_q[i] <= res_q[i-1];
                        flg_q[i] <= flg_q[i-1];
                    end
                end
            end
        end
    end

endmodule
